button_conditioner_multi: RTL

Parametrised N-channel push-button front end that replaces per-button debounce and edge-detector pairs in the game controllers. Each channel does the following in order:
- polarity correction
- 2-flop synchronisation
- counter-based debounce
- a per-channel press FSM producing press, release, long-press and auto-repeat pulses

It also gives a one-hot-to-index summary of simultaneous presses for UC opcode logic. It sits between board pins and the controller FD/UC.

---
 rtl/button_conditioner_multi_pkg.sv | 17 +
 rtl/button_conditioner_multi_channel.sv | 174 +++++++++++++++++
 rtl/button_conditioner_multi.sv | 62 ++++++
 3 files changed

// File: rtl/button_conditioner_multi_pkg.sv
// Shared definitions for the multi-channel button conditioner:
// press-FSM state encoding and the counter width helper.
package button_cond_pkg;

  // Per-channel press state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  // Bits needed for a counter that must represent 0..max_val (never below 1)
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_multi_channel.sv
// Single button channel: polarity fix, 2-flop synchroniser, counter
// debounce and a press/hold/repeat FSM with maskable registered pulses.
module button_channel
  import button_cond_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   HOLD_CYCLES     = 50000000,
  parameter int   REPEAT_CYCLES   = 10000000,
  parameter logic ACTIVE_LOW_BIT  = 1'b0,
  parameter logic REPEAT_EN_BIT   = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn_raw,
  input  logic i_in_mask,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_repeat_pulse
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic              w_pol;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_stable;
  logic [DB_W-1:0]   r_db_cnt;
  logic              w_accept;
  logic              w_rise;
  logic              w_fall;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [REP_W-1:0]  r_rep_cnt;
  logic [REP_W-1:0]  w_rep_nxt;

  logic              w_press_evt;
  logic              w_release_evt;
  logic              w_long_evt;
  logic              w_repeat_evt;

  logic              r_press;
  logic              r_release;
  logic              r_long_press;
  logic              r_repeat_pulse;

  // Normalise so that 1 always means "pressed" before synchronising
  assign w_pol = i_btn_raw ^ ACTIVE_LOW_BIT;

  // A level change is accepted once the synced input has differed for the full window
  assign w_accept = (r_sync2 != r_stable) && (r_db_cnt == DB_LAST);
  assign w_rise   = w_accept & r_sync2;
  assign w_fall   = w_accept & ~r_sync2;

  // Synchroniser and debounce counter; any return to the stable value restarts the count
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_pol;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_stable) begin
        if (r_db_cnt == DB_LAST) begin
          r_stable <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Press FSM next state, hold/repeat counters and raw pulse events; a fall overrides everything
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_rep_nxt     = r_rep_cnt;
    w_press_evt   = 1'b0;
    w_release_evt = 1'b0;
    w_long_evt    = 1'b0;
    w_repeat_evt  = 1'b0;
    if (w_fall) begin
      w_state_nxt   = ST_IDLE;
      w_hold_nxt    = '0;
      w_rep_nxt     = '0;
      w_release_evt = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_PRESSED;
            w_hold_nxt  = '0;
            w_press_evt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = ST_HELD;
            w_hold_nxt  = '0;
            w_rep_nxt   = '0;
            w_long_evt  = 1'b1;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (r_rep_cnt == REP_LAST) begin
            w_rep_nxt    = '0;
            w_repeat_evt = REPEAT_EN_BIT;
          end else begin
            w_rep_nxt = r_rep_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state and counters; mask only gates pulses, never this state
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
    end
  end

  // Registered pulses, dropped (not deferred) when the channel is masked
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_press        <= 1'b0;
      r_release      <= 1'b0;
      r_long_press   <= 1'b0;
      r_repeat_pulse <= 1'b0;
    end else begin
      r_press        <= w_press_evt   & ~i_in_mask;
      r_release      <= w_release_evt & ~i_in_mask;
      r_long_press   <= w_long_evt    & ~i_in_mask;
      r_repeat_pulse <= w_repeat_evt  & ~i_in_mask;
    end
  end

  assign o_level        = r_stable;
  assign o_press        = r_press;
  assign o_release      = r_release;
  assign o_long_press   = r_long_press;
  assign o_repeat_pulse = r_repeat_pulse;

endmodule

// File: rtl/button_conditioner_multi.sv
// N-channel push-button front end: one conditioning channel per pin plus
// a lowest-index encoder over the registered press vector.
module button_conditioner_multi
  import button_cond_pkg::*;
#(
  parameter int              N_CH            = 9,
  parameter int              DEBOUNCE_CYCLES = 500000,
  parameter int              HOLD_CYCLES     = 50000000,
  parameter int              REPEAT_CYCLES   = 10000000,
  parameter logic [N_CH-1:0] ACTIVE_LOW      = {N_CH{1'b0}},
  parameter logic [N_CH-1:0] REPEAT_EN       = {N_CH{1'b0}},
  localparam int             IDX_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [N_CH-1:0]  i_btn_raw,
  input  logic [N_CH-1:0]  i_in_mask,
  output logic [N_CH-1:0]  o_level,
  output logic [N_CH-1:0]  o_press,
  output logic [N_CH-1:0]  o_release,
  output logic [N_CH-1:0]  o_long_press,
  output logic [N_CH-1:0]  o_repeat_pulse,
  output logic             o_any_press,
  output logic [IDX_W-1:0] o_press_idx
);

  logic [N_CH-1:0]  w_press;
  logic [IDX_W-1:0] w_idx;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW_BIT  (ACTIVE_LOW[g]),
      .REPEAT_EN_BIT   (REPEAT_EN[g])
    ) u_channel (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_btn_raw      (i_btn_raw[g]),
      .i_in_mask      (i_in_mask[g]),
      .o_level        (o_level[g]),
      .o_press        (w_press[g]),
      .o_release      (o_release[g]),
      .o_long_press   (o_long_press[g]),
      .o_repeat_pulse (o_repeat_pulse[g])
    );
  end

  // Lowest set press bit wins: scan high to low so lower indices overwrite
  always_comb begin
    w_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_idx = w_press[i] ? IDX_W'(i) : w_idx;
    end
  end

  assign o_press     = w_press;
  assign o_any_press = |w_press;
  assign o_press_idx = w_idx;

endmodule
